// File: rtl/alu_seq_pkg.sv
// Shared constants and FSM encoding for the ALU command sequencer.
package alu_seq_pkg;

  localparam int DATA_W = 8;

  // Command codes carried on cmd_op
  localparam logic [2:0] CMD_ADD  = 3'b000;
  localparam logic [2:0] CMD_SUB  = 3'b001;
  localparam logic [2:0] CMD_LOAD = 3'b010;
  localparam logic [2:0] CMD_MUL  = 3'b011;
  localparam logic [2:0] CMD_READ = 3'b100;

  // Operation codes understood by alu_7bits
  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    RESP = 2'b11
  } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command and response handshake bundle between decode front end and sequencer.
interface alu_sequencer_if;
  import alu_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              rsp_err;
  logic              busy;

  // Front end side: issues commands, consumes responses
  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, busy
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu_7bits.sv
// Shared combinational ALU datapath (8-bit operands, modulo-256 results).
module alu_7bits (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [2:0] op,
  output logic [7:0] S
);
  // Operation select; carries and borrows are dropped
  always_comb begin
    S = A + B;
    case (op)
      3'b000:  S = A + B;
      3'b001:  S = A - B;
      3'b010:  S = A & B;
      3'b011:  S = A | B;
      3'b100:  S = A ^ B;
      default: S = A;
    endcase
  end
endmodule

// File: rtl/alu_sequencer.sv
// Accumulator controller sequencing alu_7bits from a command stream.
// Optional feature macro ALU_SEQ_MUL_EN: compiles in the iterative shift-add
// multiplier; without it op 011 is answered as an illegal command.
module alu_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus
);
  import alu_seq_pkg::*;

  state_e            state, state_nxt;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] data_q, acc;
  logic [DATA_W-1:0] alu_a, alu_b, alu_s;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] exec_res;
  logic              exec_err;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero, rsp_err;
  logic              accept;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
  logic [DATA_W-1:0] prod, mcand, mplier, prod_nxt;
  logic [2:0]        cnt;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = (state == RESP);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_zero  = rsp_zero;
  assign bus.rsp_err   = rsp_err;

  alu_7bits u_alu (
    .A  (alu_a),
    .B  (alu_b),
    .op (alu_op),
    .S  (alu_s)
  );

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (MUL_EN && bus.cmd_op == CMD_MUL) ? MUL : EXEC;
      EXEC: state_nxt = RESP;
`ifdef ALU_SEQ_MUL_EN
      MUL:  if (cnt == 3'd7) state_nxt = RESP;
`endif
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operand steering: accumulator path normally, product path while multiplying
  always_comb begin
    alu_a  = acc;
    alu_b  = data_q;
    alu_op = (op_q == CMD_SUB) ? ALU_OP_SUB : ALU_OP_ADD;
`ifdef ALU_SEQ_MUL_EN
    if (state == MUL) begin
      alu_a  = prod;
      alu_b  = mcand;
      alu_op = ALU_OP_ADD;
    end
`endif
  end

  // Single-cycle command result; unknown codes leave acc untouched and flag an error
  always_comb begin
    exec_res = acc;
    exec_err = 1'b0;
    case (op_q)
      CMD_ADD, CMD_SUB: exec_res = alu_s;
      CMD_LOAD:         exec_res = data_q;
      CMD_READ:         exec_res = acc;
      default:          exec_err = 1'b1;
    endcase
  end

  // State, latched command, accumulator and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      data_q   <= '0;
      acc      <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= bus.cmd_op;
        data_q <= bus.cmd_data;
      end
      if (state == EXEC) begin
        acc      <= exec_res;
        rsp_data <= exec_res;
        rsp_zero <= (exec_res == '0);
        rsp_err  <= exec_err;
      end
`ifdef ALU_SEQ_MUL_EN
      if (state == MUL && cnt == 3'd7) begin
        acc      <= prod_nxt;
        rsp_data <= prod_nxt;
        rsp_zero <= (prod_nxt == '0);
        rsp_err  <= 1'b0;
      end
`endif
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // Partial product takes the adder sum only when the current multiplier bit is set
  assign prod_nxt = mplier[0] ? alu_s : prod;

  // Shift-add registers: seeded at acceptance, one multiplier bit per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      prod   <= '0;
      mcand  <= acc;
      mplier <= bus.cmd_data;
      cnt    <= '0;
    end else if (state == MUL) begin
      prod   <= prod_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 3'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  alu_sequencer_if bus ();

  alu_sequencer #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one command and collect its response; lat = -1 if a handshake never completes
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] d,
                        output logic [7:0] rd, output logic rz, output logic re,
                        output int lat);
    int n;
    rd = 8'h00; rz = 1'b0; re = 1'b0; lat = -1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.cmd_ready) return;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = d;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'b000; bus.cmd_data = 8'hA5;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.rsp_valid) return;
    lat = n; rd = bus.rsp_data; rz = bus.rsp_zero; re = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'b000; bus.cmd_data = 8'h00; bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready: got %b expected 0", bus.cmd_ready); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    rst = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL post_reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    checks++; if ({bus.rsp_data, bus.rsp_zero, bus.rsp_err} !== 10'h0) begin
      fails++; $display("FAIL reset_rsp_regs: got data=%h zero=%b err=%b expected 00/0/0", bus.rsp_data, bus.rsp_zero, bus.rsp_err);
    end
  endtask

  task automatic test_add_sub();
    logic [2:0] ops  [6] = '{CMD_ADD, CMD_SUB, CMD_SUB, CMD_ADD, CMD_ADD, CMD_SUB};
    logic [7:0] ld   [6] = '{8'h95,   8'h95,   8'h0A,   8'h0A,   8'hFF,   8'h00};
    logic [7:0] opnd [6] = '{8'h27,   8'h27,   8'hD0,   8'hD0,   8'h01,   8'h01};
    logic [7:0] exp_d[6] = '{8'hBC,   8'h6E,   8'h3A,   8'hDA,   8'h00,   8'hFF};
    logic [7:0] rd; logic rz, re; int lat;
    for (int i = 0; i < 6; i++) begin
      // last vector chains on the previous result instead of reloading
      if (i != 5) begin
        do_cmd(CMD_LOAD, ld[i], rd, rz, re, lat);
        checks++; if (rd !== ld[i] || lat !== 1) begin
          fails++; $display("FAIL load[%0d]: got %h lat %0d expected %h lat 1", i, rd, lat, ld[i]);
        end
      end
      do_cmd(ops[i], opnd[i], rd, rz, re, lat);
      checks++; if (rd !== exp_d[i]) begin fails++; $display("FAIL arith_data[%0d]: got %h expected %h", i, rd, exp_d[i]); end
      checks++; if (rz !== (exp_d[i] == 8'h00) || re !== 1'b0) begin
        fails++; $display("FAIL arith_flags[%0d]: got zero=%b err=%b expected zero=%b err=0", i, rz, re, exp_d[i] == 8'h00);
      end
      checks++; if (lat !== 1) begin fails++; $display("FAIL arith_latency[%0d]: got %0d expected 1", i, lat); end
    end
  endtask

  task automatic test_mul();
    logic [7:0] rd; logic rz, re; int lat;
`ifdef ALU_SEQ_MUL_EN
    logic [7:0] ld   [2] = '{8'h95, 8'h0A};
    logic [7:0] opnd [2] = '{8'h27, 8'h0D};
    logic [7:0] exp_d[2] = '{8'hB3, 8'h82};
    for (int i = 0; i < 2; i++) begin
      do_cmd(CMD_LOAD, ld[i], rd, rz, re, lat);
      do_cmd(CMD_MUL, opnd[i], rd, rz, re, lat);
      checks++; if (rd !== exp_d[i] || re !== 1'b0) begin
        fails++; $display("FAIL mul_data[%0d]: got %h err %b expected %h err 0", i, rd, re, exp_d[i]);
      end
      checks++; if (lat !== 8) begin fails++; $display("FAIL mul_latency[%0d]: got %0d expected 8", i, lat); end
    end
    do_cmd(CMD_READ, 8'h00, rd, rz, re, lat);
    checks++; if (rd !== 8'h82) begin fails++; $display("FAIL mul_acc_read: got %h expected 82", rd); end
`else
    do_cmd(CMD_LOAD, 8'h0A, rd, rz, re, lat);
    do_cmd(CMD_MUL, 8'h0D, rd, rz, re, lat);
    checks++; if (re !== 1'b1 || rd !== 8'h0A) begin
      fails++; $display("FAIL mul_disabled: got data %h err %b expected 0a err 1", rd, re);
    end
    checks++; if (lat !== 1) begin fails++; $display("FAIL mul_disabled_latency: got %0d expected 1", lat); end
    do_cmd(CMD_READ, 8'h00, rd, rz, re, lat);
    checks++; if (rd !== 8'h0A || re !== 1'b0) begin
      fails++; $display("FAIL read_after_mul: got %h err %b expected 0a err 0", rd, re);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [7:0] rd; logic rz, re; int lat; int n;
    do_cmd(CMD_LOAD, 8'h5C, rd, rz, re, lat);
    bus.cmd_valid = 1'b1; bus.cmd_op = CMD_LOAD; bus.cmd_data = 8'h71;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    // a competing command is presented the whole time the response is stalled
    bus.cmd_valid = 1'b1; bus.cmd_op = CMD_ADD; bus.cmd_data = 8'h01;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h71) begin
        fails++; $display("FAIL stall_rsp[%0d]: got valid %b data %h expected 1 71", i, bus.rsp_valid, bus.rsp_data);
      end
      checks++; if (bus.cmd_ready !== 1'b0) begin fails++; $display("FAIL stall_cmd_ready[%0d]: got %b expected 0", i, bus.cmd_ready); end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL release_cmd_ready: got %b expected 1", bus.cmd_ready); end
    do_cmd(CMD_READ, 8'h00, rd, rz, re, lat);
    checks++; if (rd !== 8'h71) begin fails++; $display("FAIL stall_no_accept: got %h expected 71", rd); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; logic rz, re; int lat;
    do_cmd(CMD_LOAD, 8'h03, rd, rz, re, lat);
    bus.cmd_valid = 1'b1; bus.cmd_op = CMD_MUL; bus.cmd_data = 8'h05;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    repeat (3) @(posedge clk);
    #1;
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset: got valid %b busy %b ready %b expected 0 0 1", bus.rsp_valid, bus.busy, bus.cmd_ready);
    end
    do_cmd(CMD_READ, 8'h00, rd, rz, re, lat);
    checks++; if (rd !== 8'h00 || rz !== 1'b1 || re !== 1'b0) begin
      fails++; $display("FAIL read_after_reset: got %h zero %b err %b expected 00 1 0", rd, rz, re);
    end
    do_cmd(3'b110, 8'h44, rd, rz, re, lat);
    checks++; if (re !== 1'b1 || rd !== 8'h00 || lat !== 1) begin
      fails++; $display("FAIL illegal_op: got err %b data %h lat %0d expected 1 00 1", re, rd, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
